sm83_irq_ctrl_od: RTL and testbench

Parametrised N-channel interrupt controller built around the open-drain IRQ wired-AND cell style. It holds per-channel request flags and enable masks and detects request edges through a synchroniser. It drives an active-low open-drain request line, with a fall-only drive and release to Z. A priority-resolving acknowledge handshake returns the winning channel index and clears its flag.

---
 rtl/sm83_irq_ctrl_od.sv | 141 ++++++++++++++
 tb/tb_sm83_irq_ctrl_od.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sm83_irq_ctrl_od.sv
// N-channel interrupt controller: synchronised request edges, flag/enable registers,
// an open-drain active-low request line and a priority-resolving acknowledge handshake.
module sm83_irq_ctrl_od #(
    parameter  int unsigned N       = 5,
    parameter  int unsigned L_irq_n = 69,
    localparam int unsigned VEC_W   = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             ime,
    input  logic             wr_if,
    input  logic             wr_ie,
    input  logic [N-1:0]     wr_data,
    output logic [N-1:0]     rd_if,
    output logic [N-1:0]     rd_ie,
    input  logic             ack,
    output logic [VEC_W-1:0] vec,
    output logic             vec_valid,
    output tri               irq_n
);

    if (N < 1 || N > 16) begin : g_bad_n
        $error("sm83_irq_ctrl_od: N must be in 1..16");
    end
    if (L_irq_n < 1) begin : g_bad_load
        $error("sm83_irq_ctrl_od: L_irq_n must be non-zero");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LATCH = 2'd1,
        S_CLEAR = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [N-1:0]     sync1_q, sync1_d;
    logic [N-1:0]     sync2_q, sync2_d;
    logic [N-1:0]     prev_q, prev_d;
    logic [N-1:0]     flags_q, flags_d;
    logic [N-1:0]     ie_q, ie_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic             hit_q, hit_d;
    logic             vec_valid_q, vec_valid_d;

    logic [N-1:0]     req_edge;
    logic [N-1:0]     pending;
    logic [N-1:0]     base;
    logic             found;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            flags_q     <= '0;
            ie_q        <= '0;
            vec_q       <= '0;
            hit_q       <= 1'b0;
            vec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
            flags_q     <= flags_d;
            ie_q        <= ie_d;
            vec_q       <= vec_d;
            hit_q       <= hit_d;
            vec_valid_q <= vec_valid_d;
        end
    end

    // Flag precedence: write replaces, handshake clear applies only without a write,
    // and a fresh request edge is OR-ed in last so it always survives.
    always_comb begin
        sync1_d  = req;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        req_edge = sync2_q & ~prev_q;
        pending  = flags_q & ie_q;
        base     = wr_if ? wr_data : flags_q;
        if (state_q == S_CLEAR && hit_q && !wr_if) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (VEC_W'(i) == vec_q) begin
                    base[i] = 1'b0;
                end
            end
        end
        flags_d = base | req_edge;
        ie_d    = wr_ie ? wr_data : ie_q;
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        hit_d       = hit_q;
        vec_valid_d = vec_valid_q;
        found       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ack) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                vec_d = '0;
                for (int unsigned i = 0; i < N; i++) begin
                    if (pending[i] && !found) begin
                        vec_d = VEC_W'(i);
                        found = 1'b1;
                    end
                end
                hit_d   = found;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                vec_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (!ack) begin
                    vec_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_if     = flags_q;
    assign rd_ie     = ie_q;
    assign vec       = vec_q;
    assign vec_valid = vec_valid_q;

    // Open drain: only ever pulls low; the high level comes from the external pull-up.
    assign irq_n = (ime && (|pending)) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_sm83_irq_ctrl_od.sv
// Bench for sm83_irq_ctrl_od: directed vector table, two multi-cycle corner sequences,
// then randomized traffic compared against a behavioural model.
module tb_sm83_irq_ctrl_od;

    localparam int unsigned N  = 5;
    localparam int unsigned VW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req, wr_data, rd_if, rd_ie;
    logic          ime, wr_if, wr_ie, ack;
    logic [VW-1:0] vec;
    logic          vec_valid;
    tri            irq_n;

    pullup (irq_n);

    sm83_irq_ctrl_od #(.N(N), .L_irq_n(69)) dut (
        .clk(clk), .reset(reset), .req(req), .ime(ime), .wr_if(wr_if), .wr_ie(wr_ie),
        .wr_data(wr_data), .rd_if(rd_if), .rd_ie(rd_ie), .ack(ack), .vec(vec),
        .vec_valid(vec_valid), .irq_n(irq_n)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e_if, input logic [4:0] e_ie,
                           input logic [2:0] e_vec, input logic e_vv, input logic e_irqn);
        chk({tag, ".rd_if"}, 32'(rd_if), 32'(e_if));
        chk({tag, ".rd_ie"}, 32'(rd_ie), 32'(e_ie));
        chk({tag, ".vec"}, 32'(vec), 32'(e_vec));
        chk({tag, ".vec_valid"}, 32'(vec_valid), 32'(e_vv));
        chk({tag, ".irq_n"}, 32'(irq_n), 32'(e_irqn));
    endtask

    task automatic drive(input logic [4:0] rq, input logic im, input logic wi, input logic we,
                         input logic [4:0] wd, input logic ak);
        req = rq; ime = im; wr_if = wi; wr_ie = we; wr_data = wd; ack = ak;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic [4:0] req;
        logic       ime, wr_if, wr_ie;
        logic [4:0] wd;
        logic       ack;
        logic [4:0] e_if, e_ie;
        logic [2:0] e_vec;
        logic       e_vv, e_irqn;
    } vec_t;

    function automatic vec_t mk(logic [4:0] rq, logic im, logic wi, logic we, logic [4:0] wd,
                                logic ak, logic [4:0] ei, logic [4:0] ee, logic [2:0] ev,
                                logic evv, logic eir);
        vec_t v;
        v.req = rq; v.ime = im; v.wr_if = wi; v.wr_ie = we; v.wd = wd; v.ack = ak;
        v.e_if = ei; v.e_ie = ee; v.e_vec = ev; v.e_vv = evv; v.e_irqn = eir;
        return v;
    endfunction

    // Behavioural model state: request history as raw samples, handshake as a step count.
    logic [4:0] m_flags, m_ie, m_hist[3];
    logic [2:0] m_vec;
    logic       m_vv, m_hit;
    int         m_ph;

    task automatic model_reset();
        m_flags = '0; m_ie = '0; m_vec = '0; m_vv = 1'b0; m_hit = 1'b0; m_ph = 0;
        for (int i = 0; i < 3; i++) m_hist[i] = '0;
    endtask

    task automatic model_step();
        logic [4:0] rises, pend, base, tmp;
        int idx;
        // A request counts as new when seen high two samples ago but low three samples ago.
        rises = m_hist[1] & ~m_hist[2];
        pend  = m_flags & m_ie;
        base  = wr_if ? wr_data : m_flags;
        if (m_ph == 2 && m_hit && !wr_if) base = base & ~(5'b1 << m_vec);
        if (wr_ie) m_ie = wr_data;
        case (m_ph)
            0: if (ack) m_ph = 1;
            1: begin
                m_hit = (pend != 0);
                idx = 0;
                tmp = pend;
                if (m_hit) while (tmp[0] == 1'b0) begin tmp = tmp >> 1; idx++; end
                m_vec = 3'(idx);
                m_ph = 2;
            end
            2: begin m_vv = 1'b1; m_ph = 3; end
            default: if (!ack) begin m_vv = 1'b0; m_ph = 0; end
        endcase
        m_flags = base | rises;
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = req;
    endtask

    vec_t tbl[$];

    initial begin
        drive(5'b0, 1'b0, 1'b0, 1'b0, 5'b0, 1'b0);
        reset = 1'b1;
        #12;
        chk_all("reset_hold", 5'b0, 5'b0, 3'd0, 1'b0, 1'b1);
        do_reset();
        chk_all("after_reset", 5'b0, 5'b0, 3'd0, 1'b0, 1'b1);

        //          req      ime  wif  wie  wd        ack   e_if      e_ie      vec  vv   irqn
        tbl.push_back(mk(5'b00000, 0, 0, 0, 5'b00000, 0, 5'b00000, 5'b00000, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 0, 1, 5'b00101, 0, 5'b00000, 5'b00101, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00100, 1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00101, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00100, 1, 0, 0, 5'b00000, 0, 5'b00000, 5'b00101, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00100, 1, 0, 0, 5'b00000, 0, 5'b00100, 5'b00101, 3'd0, 0, 0));
        tbl.push_back(mk(5'b00100, 0, 0, 0, 5'b00000, 0, 5'b00100, 5'b00101, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 1, 0, 5'b00000, 0, 5'b00000, 5'b00101, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 1, 1, 5'b10110, 0, 5'b10110, 5'b10110, 3'd0, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 1, 5'b11110, 0, 5'b10110, 5'b11110, 3'd0, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10110, 5'b11110, 3'd0, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10110, 5'b11110, 3'd1, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10100, 5'b11110, 3'd1, 1, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10100, 5'b11110, 3'd1, 1, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 0, 5'b10100, 5'b11110, 3'd1, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 0, 5'b10100, 5'b11110, 3'd1, 0, 0));
        tbl.push_back(mk(5'b00000, 1, 0, 1, 5'b00000, 0, 5'b10100, 5'b00000, 3'd1, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10100, 5'b00000, 3'd1, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10100, 5'b00000, 3'd0, 0, 1));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 1, 5'b10100, 5'b00000, 3'd0, 1, 1));
        tbl.push_back(mk(5'b00000, 1, 0, 0, 5'b00000, 0, 5'b10100, 5'b00000, 3'd0, 0, 1));

        foreach (tbl[i]) begin
            drive(tbl[i].req, tbl[i].ime, tbl[i].wr_if, tbl[i].wr_ie, tbl[i].wd, tbl[i].ack);
            tick();
            chk_all($sformatf("tbl%0d", i), tbl[i].e_if, tbl[i].e_ie, tbl[i].e_vec,
                    tbl[i].e_vv, tbl[i].e_irqn);
        end

        // Request edge landing in the clear cycle keeps the flag set.
        do_reset();
        drive(5'b00000, 1'b1, 1'b1, 1'b0, 5'b10110, 1'b0); tick();
        drive(5'b00000, 1'b1, 1'b0, 1'b1, 5'b11110, 1'b0); tick();
        drive(5'b00010, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1); tick();
        tick();
        chk("setclr.vec_latch", 32'(vec), 32'd1);
        tick();
        chk_all("setclr.done", 5'b10110, 5'b11110, 3'd1, 1'b1, 1'b0);
        ack = 1'b0; tick();
        chk("setclr.exit_vv", 32'(vec_valid), 32'd0);

        // Reset asserted mid-handshake, then a fresh handshake.
        do_reset();
        drive(5'b00000, 1'b1, 1'b1, 1'b1, 5'b00001, 1'b0); tick();
        chk_all("rst_mid.setup", 5'b00001, 5'b00001, 3'd0, 1'b0, 1'b0);
        drive(5'b00000, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b1); tick();
        tick();
        #2 reset = 1'b1;
        #1;
        chk_all("rst_mid.async", 5'b0, 5'b0, 3'd0, 1'b0, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(5'b00000, 1'b1, 1'b1, 1'b1, 5'b00010, 1'b1); tick();
        chk("rst_mid.relatch_vv", 32'(vec_valid), 32'd0);
        wr_if = 1'b0; wr_ie = 1'b0; tick();
        chk("rst_mid.latch_vec", 32'(vec), 32'd1);
        chk("rst_mid.latch_vv", 32'(vec_valid), 32'd0);
        chk("rst_mid.latch_irq", 32'(irq_n), 32'd0);
        tick();
        chk_all("rst_mid.done", 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b1);

        // Randomized traffic against the model.
        do_reset();
        model_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(3) == 0) req[$urandom_range(N - 1)] ^= 1'b1;
            if ($urandom_range(5) == 0) ack = ~ack;
            if ($urandom_range(9) == 0) ime = ~ime;
            wr_if   = ($urandom_range(15) == 0);
            wr_ie   = ($urandom_range(11) == 0);
            wr_data = 5'($urandom);
            @(posedge clk);
            model_step();
            #1;
            chk_all($sformatf("rnd%0d", c), m_flags, m_ie, m_vec, m_vv,
                    (ime && ((m_flags & m_ie) != 0)) ? 1'b0 : 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
